// File: rtl/imem_pkg.sv
// Shared types and default geometry for the instruction memory with program loader.
package imem_pkg;

  localparam int IMEM_DATA_W = 32;
  localparam int IMEM_ADDR_W = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/imem_prog_if.sv
// Fetch port and loader handshake bundled for the instruction memory.
interface imem_prog_if
  import imem_pkg::*;
#(
  parameter int DATA_W = IMEM_DATA_W,
  parameter int ADDR_W = IMEM_ADDR_W
) ();

  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              ld_start;
  logic [ADDR_W-1:0] ld_base;
  logic [ADDR_W:0]   ld_count;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              ld_busy;
  logic              ld_done;

  modport master (
    output fetch_en, fetch_addr, ld_start, ld_base, ld_count, ld_valid, ld_data,
    input  fetch_data, fetch_valid, ld_ready, ld_busy, ld_done
  );

  modport slave (
    input  fetch_en, fetch_addr, ld_start, ld_base, ld_count, ld_valid, ld_data,
    output fetch_data, fetch_valid, ld_ready, ld_busy, ld_done
  );

endinterface

// File: rtl/imem_ram.sv
// 1R1W synchronous RAM with enabled registered read; no reset so it maps to block RAM.
module imem_ram
  import imem_pkg::*;
#(
  parameter int DATA_W = IMEM_DATA_W,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_prog.sv
// Instruction memory: one-cycle IF fetch port plus a burst loader that owns the write port.
module imem_prog
  import imem_pkg::*;
#(
  parameter int DATA_W = IMEM_DATA_W,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic        clk,
  input  logic        rst_n,
  imem_prog_if.slave  bus
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W:0]   r_remaining;
  logic              r_fetch_valid;
  logic              r_has_data;
  logic [DATA_W-1:0] w_ram_q;
  logic              w_ld_ready;
  logic              w_ld_busy;
  logic              w_ld_done;
  logic              w_beat;
  logic              w_fetch_acc;
  logic              w_fetch_drop;

  // Nothing touches the RAM during the reset cycle, so an abandoned beat is never written.
  assign w_beat       = rst_n && (r_state == LOAD) && bus.ld_valid;
  assign w_fetch_acc  = rst_n && (r_state == IDLE) && bus.fetch_en;
  assign w_fetch_drop = (r_state != IDLE) && bus.fetch_en;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_ld_ready = 1'b0;
    w_ld_busy  = 1'b1;
    w_ld_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_ld_busy = 1'b0;
        if (bus.ld_start) w_next = (bus.ld_count != '0) ? LOAD : DONE;
      end
      LOAD: begin
        w_ld_ready = 1'b1;
        if (bus.ld_valid && (r_remaining == (ADDR_W+1)'(1))) w_next = DONE;
      end
      DONE: begin
        w_ld_done = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Write pointer wraps naturally at DEPTH because it is exactly ADDR_W bits wide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_remaining <= '0;
    end else if ((r_state == IDLE) && bus.ld_start) begin
      r_wptr      <= bus.ld_base;
      r_remaining <= bus.ld_count;
    end else if (w_beat) begin
      r_wptr      <= r_wptr + 1'b1;
      r_remaining <= r_remaining - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_valid <= 1'b0;
      r_has_data    <= 1'b0;
    end else if (w_fetch_acc) begin
      r_fetch_valid <= 1'b1;
      r_has_data    <= 1'b1;
    end else if (w_fetch_drop) begin
      r_fetch_valid <= 1'b0;
    end
  end

  imem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_re    (w_fetch_acc),
    .i_raddr (bus.fetch_addr),
    .o_rdata (w_ram_q),
    .i_we    (w_beat),
    .i_waddr (r_wptr),
    .i_wdata (bus.ld_data)
  );

  // RAM output register only moves on an accepted fetch, so it already holds on stall.
  assign bus.fetch_data  = r_has_data ? w_ram_q : '0;
  assign bus.fetch_valid = r_fetch_valid;
  assign bus.ld_ready    = w_ld_ready;
  assign bus.ld_busy     = w_ld_busy;
  assign bus.ld_done     = w_ld_done;

endmodule

// File: tb/tb_imem_prog.sv
// Directed bench for imem_prog: load bursts, wraparound, empty load, stall, mid-load fetch and reset.
module tb_imem_prog;

  localparam int DW = 32;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  imem_prog_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  imem_prog #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, let a rising edge pass, and return at the following falling edge.
  task automatic applyStimulus(input logic fe, input logic [AW-1:0] fa,
                               input logic ls, input logic [AW-1:0] lb, input logic [AW:0] lc,
                               input logic lv, input logic [DW-1:0] ld);
    bus.fetch_en   = fe;
    bus.fetch_addr = fa;
    bus.ld_start   = ls;
    bus.ld_base    = lb;
    bus.ld_count   = lc;
    bus.ld_valid   = lv;
    bus.ld_data    = ld;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    applyStimulus(1'b1, a, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic startLoad(input logic [AW-1:0] b, input logic [AW:0] c);
    applyStimulus(1'b0, '0, 1'b1, b, c, 1'b0, '0);
  endtask

  task automatic beat(input logic [DW-1:0] d);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, d);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkLoader(input string tag, input logic rdy, input logic busy, input logic done);
    checkOutput({tag, "_ready"}, 64'(bus.ld_ready), 64'(rdy));
    checkOutput({tag, "_busy"},  64'(bus.ld_busy),  64'(busy));
    checkOutput({tag, "_done"},  64'(bus.ld_done),  64'(done));
  endtask

  task automatic checkFetch(input string tag, input logic [DW-1:0] d, input logic v);
    checkOutput({tag, "_data"},  64'(bus.fetch_data),  64'(d));
    checkOutput({tag, "_valid"}, 64'(bus.fetch_valid), 64'(v));
  endtask

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    idleCycle();
    idleCycle();
    checkFetch("reset", '0, 1'b0);
    checkLoader("reset", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    $display("[TB] load base 0 count 4");
    startLoad(9'd0, 10'd4);
    for (int i = 0; i < 4; i++) begin
      checkLoader("t1_load", 1'b1, 1'b1, 1'b0);
      beat(32'hA0 + 32'(i));
    end
    checkLoader("t1_done", 1'b0, 1'b1, 1'b1);
    idleCycle();
    checkLoader("t1_idle", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      fetch(AW'(i));
      checkFetch("t1_fetch", 32'hA0 + 32'(i), 1'b1);
    end

    $display("[TB] wrapping load base 510 count 4");
    startLoad(9'd510, 10'd4);
    for (int i = 0; i < 4; i++) beat(32'hB0 + 32'(i));
    checkLoader("t2_done", 1'b0, 1'b1, 1'b1);
    idleCycle();
    fetch(9'd510); checkFetch("t2_a510", 32'hB0, 1'b1);
    fetch(9'd511); checkFetch("t2_a511", 32'hB1, 1'b1);
    fetch(9'd0);   checkFetch("t2_a0",   32'hB2, 1'b1);
    fetch(9'd1);   checkFetch("t2_a1",   32'hB3, 1'b1);
    fetch(9'd2);   checkFetch("t2_a2",   32'hA2, 1'b1);

    $display("[TB] empty load");
    startLoad(9'd0, 10'd0);
    checkLoader("t3_done", 1'b0, 1'b1, 1'b1);
    idleCycle();
    checkLoader("t3_idle", 1'b0, 1'b0, 1'b0);
    fetch(9'd0); checkFetch("t3_a0", 32'hB2, 1'b1);

    $display("[TB] stall hold and fetch during load");
    startLoad(9'h10, 10'd1);
    beat(32'hC0);
    idleCycle();
    fetch(9'h10); checkFetch("t4_fetch", 32'hC0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkFetch("t4_stall", 32'hC0, 1'b1);
    end
    startLoad(9'h20, 10'd1);
    applyStimulus(1'b1, 9'd0, 1'b0, '0, '0, 1'b0, '0);
    checkFetch("t4_drop", 32'hC0, 1'b0);
    checkLoader("t4_still_load", 1'b1, 1'b1, 1'b0);
    beat(32'hD0);
    checkLoader("t4_done", 1'b0, 1'b1, 1'b1);
    idleCycle();
    fetch(9'h20); checkFetch("t4_a20", 32'hD0, 1'b1);

    $display("[TB] bubbled load with ignored restart");
    startLoad(9'h30, 10'd3);
    beat(32'hE0);
    idleCycle();
    checkLoader("t5_bubble", 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 9'h40, 10'd5, 1'b1, 32'hE1);
    idleCycle();
    checkLoader("t5_mid", 1'b1, 1'b1, 1'b0);
    beat(32'hE2);
    checkLoader("t5_done", 1'b0, 1'b1, 1'b1);
    idleCycle();
    checkLoader("t5_idle", 1'b0, 1'b0, 1'b0);
    fetch(9'h30); checkFetch("t5_a30", 32'hE0, 1'b1);
    fetch(9'h31); checkFetch("t5_a31", 32'hE1, 1'b1);
    fetch(9'h32); checkFetch("t5_a32", 32'hE2, 1'b1);

    $display("[TB] reset during load");
    startLoad(9'h50, 10'd5);
    for (int i = 0; i < 5; i++) beat(32'hF0 + 32'(i));
    idleCycle();
    startLoad(9'h50, 10'd5);
    beat(32'h111);
    beat(32'h112);
    rst_n = 1'b0;
    applyStimulus(1'b1, 9'h50, 1'b0, '0, '0, 1'b1, 32'h113);
    checkFetch("t6_rst", '0, 1'b0);
    checkLoader("t6_rst", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    idleCycle();
    checkLoader("t6_after", 1'b0, 1'b0, 1'b0);
    fetch(9'h50); checkFetch("t6_a50", 32'h111, 1'b1);
    fetch(9'h51); checkFetch("t6_a51", 32'h112, 1'b1);
    fetch(9'h52); checkFetch("t6_a52", 32'hF2, 1'b1);
    fetch(9'h53); checkFetch("t6_a53", 32'hF3, 1'b1);
    fetch(9'h54); checkFetch("t6_a54", 32'hF4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
